// File: rtl/sync_async_pkg.sv
// Shared constants and helpers for both ends of the pulse-stretch crossing.
// Revision 1.0
`default_nettype none

package sync_async_pkg;

  localparam logic ST_LOW  = 1'b0;
  localparam logic ST_HIGH = 1'b1;

  localparam int SYNC_STAGES_DEF = 2;

  // Largest value an unsigned counter of width w can hold.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slow_domain_rx_if.sv
// Receive-side bundle: stretched level in, acknowledge and event stream out.
// Revision 1.0
`default_nettype none

interface slow_domain_rx_if #(
  parameter int CNT_W = 4
);

  logic             sig_in;
  logic             out_ready;
  logic             out_valid;
  logic [CNT_W-1:0] pend_cnt;
  logic             ack;
  logic             ovf;

  modport master (
    input  sig_in,
    input  out_ready,
    output out_valid,
    output pend_cnt,
    output ack,
    output ovf
  );

  modport slave (
    output sig_in,
    output out_ready,
    input  out_valid,
    input  pend_cnt,
    input  ack,
    input  ovf
  );

endinterface

`default_nettype wire

// File: rtl/sync_chain.sv
// Multi-flop level synchroniser with synchronous active-high reset.
// Revision 1.0
`default_nettype none

module sync_chain
  import sync_async_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_chain: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/slow_domain_rx.sv
// Slow-domain receiver: synchronise stretched level, count rising edges, drain via valid/ready.
// Optional glitch filter: SLOW_DOMAIN_RX_GLITCH_FILTER_EN. Revision 1.0
`default_nettype none

module slow_domain_rx
  import sync_async_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 4,
  parameter int FILT_LEN    = 3
) (
  input  wire logic         clk2,
  input  wire logic         rst,
  slow_domain_rx_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  generate
    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
      $error("slow_domain_rx: FILT_LEN must be in 1..15");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt
      $error("slow_domain_rx: CNT_W out of range");
    end
  endgenerate

  logic sync_q;
  logic acc_lvl;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk2),
    .rst (rst),
    .d   (bus.sig_in),
    .q   (sync_q)
  );

`ifdef SLOW_DOMAIN_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] filt_cnt;

  // Accepted level flips only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk2) begin
    if (rst) begin
      filt_cnt <= '0;
      acc_lvl  <= 1'b0;
    end else if (sync_q == acc_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      acc_lvl  <= sync_q;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  assign acc_lvl = sync_q;
`endif

  logic state;
  logic state_nxt;
  logic rise;
  logic ack_lvl;

  always_ff @(posedge clk2) begin
    if (rst) begin
      state <= ST_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOW:  if (acc_lvl)  state_nxt = ST_HIGH;
      ST_HIGH: if (!acc_lvl) state_nxt = ST_LOW;
      default: state_nxt = ST_LOW;
    endcase
  end

  always_comb begin
    rise    = (state == ST_LOW) && acc_lvl;
    ack_lvl = (state == ST_HIGH);
  end

  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             pop;

  assign pop = bus.out_valid & bus.out_ready;

  // A simultaneous edge and pop cancel out, so a full counter never overflows on that cycle.
  always_ff @(posedge clk2) begin
    if (rst) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case ({rise, pop})
        2'b10: begin
          if (cnt == CNT_MAX) begin
            ovf_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.pend_cnt  = cnt;
  assign bus.out_valid = (cnt != '0);
  assign bus.ack       = ack_lvl;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
